// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile: AXI4-Lite slave register file with NUM_REGS words of
// DATA_WIDTH bits. Writes use byte strobes. The read and write channels run
// concurrently. AW and W are captured independently in one-entry holding
// slots, and the write commits on the edge after both slots are full.
// Optional build macro AXIL_REGFILE_SLVERR_EN: when it is defined,
// out-of-range accesses answer SLVERR instead of OKAY.
module axi4_lite_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDR_WIDTH-1:0]     S_AWADDR,
  input  logic                      S_AWVALID,
  output logic                      S_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_WSTRB,
  input  logic                      S_WVALID,
  output logic                      S_WREADY,
  output logic [1:0]                S_BRESP,
  output logic                      S_BVALID,
  input  logic                      S_BREADY,
  input  logic [ADDR_WIDTH-1:0]     S_ARADDR,
  input  logic                      S_ARVALID,
  output logic                      S_ARREADY,
  output logic [DATA_WIDTH-1:0]     S_RDATA,
  output logic [1:0]                S_RRESP,
  output logic                      S_RVALID,
  input  logic                      S_RREADY
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One extra bit so that the byte size of the register file always fits.
  localparam int CMP_W    = ADDR_WIDTH + 1;
  localparam logic [CMP_W-1:0] RANGE_END = CMP_W'(NUM_REGS * BYTES);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  // Outputs stay quiet until the first edge that follows reset release.
  logic                  r_out_en;
  logic                  r_aw_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic                  r_w_full;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [BYTES-1:0]      r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_awready;
  logic                  w_wready;
  logic                  w_arready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_commit;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [NUM_REGS-1:0]   w_reg_we;
  logic [DATA_WIDTH-1:0] w_lane_mask;

  // The READYs are gated by ARESETN as well, so they drop as soon as reset
  // asserts rather than one edge later.
  assign w_awready = ARESETN & r_out_en & ~r_aw_full & ~r_bvalid;
  assign w_wready  = ARESETN & r_out_en & ~r_w_full & ~r_bvalid;
  assign w_arready = ARESETN & r_out_en & ~r_rvalid;

  assign w_aw_hs  = S_AWVALID & w_awready;
  assign w_w_hs   = S_WVALID & w_wready;
  assign w_b_hs   = r_bvalid & S_BREADY;
  assign w_ar_hs  = S_ARVALID & w_arready;
  assign w_r_hs   = r_rvalid & S_RREADY;
  assign w_commit = r_aw_full & r_w_full;

  // Range is checked on the full byte address. The index slice is only
  // trusted once the address is known to be in range.
  assign w_wr_in_range = ({1'b0, r_aw_addr} < RANGE_END);
  assign w_rd_in_range = ({1'b0, S_ARADDR} < RANGE_END);
  assign w_wr_idx      = r_aw_addr[ADDR_LSB +: IDX_W];
  assign w_rd_idx      = S_ARADDR[ADDR_LSB +: IDX_W];

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign w_lane_mask[8*gi +: 8] = {8{r_w_strb[gi]}};
    end
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
      assign w_reg_we[gi] = w_commit & w_wr_in_range & (w_wr_idx == IDX_W'(gi));
    end
  endgenerate

  assign S_AWREADY = w_awready;
  assign S_WREADY  = w_wready;
  assign S_ARREADY = w_arready;
  assign S_BVALID  = r_bvalid;
  assign S_BRESP   = r_bresp;
  assign S_RVALID  = r_rvalid;
  assign S_RRESP   = r_rresp;
  assign S_RDATA   = r_rdata;

  // Register storage: masked byte-lane merge of the held W beat on commit.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_reg_we[i]) begin
          r_regs[i] <= (r_regs[i] & ~w_lane_mask) | (r_w_data & w_lane_mask);
        end
      end
    end
  end

  // Write channel: AW and W slots fill independently. Commit raises B, and
  // no further AW or W is taken until B has been accepted.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_out_en  <= 1'b0;
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_out_en <= 1'b1;
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= S_AWADDR;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= S_WDATA;
        r_w_strb <= S_WSTRB;
      end
      if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_in_range ? RESP_OKAY : RESP_OOR;
      end
    end
  end

  // Read channel: one-cycle registered read. r_regs is sampled before any
  // same-edge commit lands, so a colliding read returns the old value.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_OOR;
      r_rdata  <= w_rd_in_range ? r_regs[w_rd_idx] : '0;
    end else if (w_r_hs) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Testbench for axi4_lite_regfile (default parameters, 32 x 32-bit words).
// The expected response for out-of-range accesses follows the
// AXIL_REGFILE_SLVERR_EN macro, the same way the design does.
module tb_axi4_lite_regfile;

  localparam int NR    = 32;
  localparam int BYTES = 4;
  localparam int unsigned RANGE = NR * BYTES;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR_EXP = 2'b10;
`else
  localparam logic [1:0] OOR_EXP = 2'b00;
`endif

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] S_AWADDR;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [31:0] S_ARADDR;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY;

  axi4_lite_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic timed_out(input string nm);
    n_checks++;
    $display("FAIL %s: got no handshake within the cycle budget, expected a handshake", nm);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_mem [NR];
  bit          m_started = 0;
  bit          m_en = 0;
  bit          m_rst_last = 0;
  bit          m_aw_have = 0;
  bit          m_w_have = 0;
  int unsigned m_aw_addr = 0;
  logic [31:0] m_w_data = '0;
  logic [3:0]  m_w_strb = '0;
  bit          m_bvalid = 0;
  logic [1:0]  m_bresp = '0;
  bit          m_rvalid = 0;
  logic [1:0]  m_rresp = '0;
  logic [31:0] m_rdata = '0;

  function automatic bit exp_awready();
    return ARESETN && m_en && !m_aw_have && !m_bvalid;
  endfunction
  function automatic bit exp_wready();
    return ARESETN && m_en && !m_w_have && !m_bvalid;
  endfunction
  function automatic bit exp_arready();
    return ARESETN && m_en && !m_rvalid;
  endfunction

  // Per-cycle compare against the model, then advance the model by one edge.
  always @(negedge ACLK) begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int unsigned a;
    logic [31:0] mask;
    if (m_started) begin
      chk("awready", 64'(S_AWREADY), 64'(exp_awready()));
      chk("wready",  64'(S_WREADY),  64'(exp_wready()));
      chk("arready", 64'(S_ARREADY), 64'(exp_arready()));
      chk("bvalid",  64'(S_BVALID),  64'(m_bvalid));
      chk("rvalid",  64'(S_RVALID),  64'(m_rvalid));
      if (m_bvalid || m_rst_last) chk("bresp", 64'(S_BRESP), 64'(m_bresp));
      if (m_rvalid || m_rst_last) begin
        chk("rdata", 64'(S_RDATA), 64'(m_rdata));
        chk("rresp", 64'(S_RRESP), 64'(m_rresp));
      end
    end
    if (!ARESETN) begin
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      m_en = 0; m_rst_last = 1; m_started = 1;
      m_aw_have = 0; m_w_have = 0; m_bvalid = 0; m_rvalid = 0;
      m_bresp = '0; m_rresp = '0; m_rdata = '0;
    end else begin
      aw_hs = S_AWVALID && exp_awready();
      w_hs  = S_WVALID && exp_wready();
      ar_hs = S_ARVALID && exp_arready();
      b_hs  = m_bvalid && S_BREADY;
      r_hs  = m_rvalid && S_RREADY;
      // The read sees memory as it was before this edge's write.
      if (ar_hs) begin
        a = S_ARADDR;
        m_rvalid = 1;
        if (a < RANGE) begin m_rdata = m_mem[a / BYTES]; m_rresp = 2'b00; end
        else begin m_rdata = '0; m_rresp = OOR_EXP; end
      end else if (r_hs) m_rvalid = 0;
      if (b_hs) m_bvalid = 0;
      if (m_aw_have && m_w_have) begin
        if (m_aw_addr < RANGE) begin
          mask = '0;
          for (int b = 0; b < BYTES; b++) if (m_w_strb[b]) mask[8*b +: 8] = 8'hFF;
          m_mem[m_aw_addr / BYTES] = (m_mem[m_aw_addr / BYTES] & ~mask) | (m_w_data & mask);
          m_bresp = 2'b00;
        end else m_bresp = OOR_EXP;
        m_bvalid = 1; m_aw_have = 0; m_w_have = 0;
      end
      if (aw_hs) begin m_aw_have = 1; m_aw_addr = S_AWADDR; end
      if (w_hs)  begin m_w_have = 1; m_w_data = S_WDATA; m_w_strb = S_WSTRB; end
      m_en = 1; m_rst_last = 0;
    end
  end

  // ---------------- stimulus tasks (entered at posedge+1) ----------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, output logic [1:0] resp, output int lat);
    bit aw_done = 0, w_done = 0, done = 0;
    int cyc = 0, hs_cyc = -1, bv_cyc = -1, stall = 0;
    resp = '0;
    while (!done) begin
      S_AWADDR = addr; S_AWVALID = !aw_done && (cyc >= aw_dly);
      S_WDATA = data; S_WSTRB = strb; S_WVALID = !w_done && (cyc >= w_dly);
      S_BREADY = (stall >= b_dly);
      @(negedge ACLK);
      if (S_AWVALID && S_AWREADY) aw_done = 1;
      if (S_WVALID && S_WREADY) w_done = 1;
      if (aw_done && w_done && hs_cyc < 0) hs_cyc = cyc;
      if (S_BVALID && bv_cyc < 0) bv_cyc = cyc;
      if (S_BVALID && S_BREADY) begin resp = S_BRESP; done = 1; end
      else if (S_BVALID) stall++;
      @(posedge ACLK); #1;
      cyc++;
      if (!done && cyc > 200) begin timed_out("write_timeout"); done = 1; end
    end
    S_AWVALID = 0; S_WVALID = 0; S_BREADY = 0;
    lat = bv_cyc - hs_cyc;
    $display("WR addr=0x%08h data=0x%08h strb=0x%h resp=%0d latency=%0d", addr, data, strb, resp, lat);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, done = 0;
    int cyc = 0, stall = 0;
    data = '0; resp = '0;
    while (!done) begin
      S_ARADDR = addr; S_ARVALID = !ar_done && (cyc >= ar_dly);
      S_RREADY = (stall >= r_dly);
      @(negedge ACLK);
      if (S_ARVALID && S_ARREADY) ar_done = 1;
      if (S_RVALID && S_RREADY) begin data = S_RDATA; resp = S_RRESP; done = 1; end
      else if (S_RVALID) stall++;
      @(posedge ACLK); #1;
      cyc++;
      if (!done && cyc > 200) begin timed_out("read_timeout"); done = 1; end
    end
    S_ARVALID = 0; S_RREADY = 0;
    $display("RD addr=0x%08h data=0x%08h resp=%0d", addr, data, resp);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [31:0] rd, waddr, raddr;
    logic [1:0]  rr, wr;
    int          lat, guard;
    time         t_wr, t_rd;
    bit          got;
    ARESETN = 0; S_AWADDR = '0; S_AWVALID = 0; S_WDATA = '0; S_WSTRB = '0;
    S_WVALID = 0; S_BREADY = 0; S_ARADDR = '0; S_ARVALID = 0; S_RREADY = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("arready_in_reset", 64'(S_ARREADY), 64'(0));
    @(posedge ACLK); #1;
    ARESETN = 1;

    // Every word reads as zero after reset.
    for (int i = 0; i < NR; i++) begin
      do_read(32'(i * BYTES), 0, 0, rd, rr);
      chk("reset_read_data", 64'(rd), 64'(0));
      chk("reset_read_resp", 64'(rr), 64'(0));
    end

    // AW and W together: BVALID appears one edge after the commit edge.
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, wr, lat);
    chk("wr08_latency", 64'(lat), 64'(2));
    chk("wr08_resp", 64'(wr), 64'(0));
    do_read(32'h08, 0, 0, rd, rr);
    chk("rd08", 64'(rd), 64'h0000_0000_DEAD_BEEF);

    // W three cycles ahead of AW.
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 3, 0, 0, wr, lat);
    chk("wr10_latency", 64'(lat), 64'(2));
    do_read(32'h10, 0, 0, rd, rr);
    chk("rd10", 64'(rd), 64'h0000_0000_DEAD_BEEF);

    // Byte-strobe merge.
    do_write(32'h04, 32'h11223344, 4'hF, 0, 0, 0, wr, lat);
    do_write(32'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0, wr, lat);
    do_read(32'h04, 0, 0, rd, rr);
    chk("rd04_strobe", 64'(rd), 64'h0000_0000_11BB_33DD);

    // A held-off B with a read of another word finishing inside the stall.
    fork
      begin do_write(32'h14, 32'h0000_0055, 4'hF, 0, 0, 5, wr, lat); t_wr = $time; end
      begin do_read(32'h08, 3, 0, rd, rr); t_rd = $time; end
    join
    chk("rd_during_b_stall", 64'(t_rd < t_wr), 64'(1));
    chk("rd_during_b_stall_data", 64'(rd), 64'h0000_0000_DEAD_BEEF);
    do_read(32'h04, 0, 4, rd, rr);
    chk("rd04_rready_stall", 64'(rd), 64'h0000_0000_11BB_33DD);

    // Out of range: 0x80 would alias word 0 if the decode ignored the range.
    do_write(32'h80, 32'hCAFEF00D, 4'hF, 0, 0, 0, wr, lat);
    chk("oor_bresp", 64'(wr), 64'(OOR_EXP));
    do_read(32'h80, 0, 0, rd, rr);
    chk("oor_rdata", 64'(rd), 64'(0));
    chk("oor_rresp", 64'(rr), 64'(OOR_EXP));
    do_read(32'h00, 0, 0, rd, rr);
    chk("word0_untouched", 64'(rd), 64'(0));

    // Reset while an AW waits in its slot with no W.
    S_AWADDR = 32'h18; S_AWVALID = 1; got = 0; guard = 0;
    while (!got && guard < 50) begin
      @(negedge ACLK); got = S_AWREADY;
      @(posedge ACLK); #1; guard++;
    end
    if (!got) timed_out("aw_before_reset");
    S_AWVALID = 0; ARESETN = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1;
    repeat (4) @(posedge ACLK);
    #1;
    do_read(32'h18, 0, 0, rd, rr);
    chk("aw_dropped_by_reset", 64'(rd), 64'(0));

    // Randomised traffic, including same-word collisions.
    for (int n = 0; n < 250; n++) begin
      int op;
      op = $urandom_range(0, 2);
      waddr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, RANGE + 31));
      raddr = ($urandom_range(0, 3) == 0) ? (waddr & ~32'h3) : 32'($urandom_range(0, RANGE + 31));
      if (op == 0) begin
        do_write(waddr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), wr, lat);
      end else if (op == 1) begin
        do_read(raddr, $urandom_range(0, 2), $urandom_range(0, 3), rd, rr);
      end else begin
        fork
          do_write(waddr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 3), wr, lat);
          do_read(raddr, $urandom_range(0, 4), $urandom_range(0, 2), rd, rr);
        join
      end
    end

    repeat (3) @(posedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
